// File: rtl/padded_pixel_streamer_pkg.sv
// Shared defaults and FSM encoding for the zero-padding pixel streamer.
package padded_pixel_streamer_pkg;

  localparam int unsigned DefDataW     = 64;
  localparam int unsigned DefMaxWidth  = 128;
  localparam int unsigned DefMaxHeight = 128;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDone
  } state_e;

endpackage

// File: rtl/raster_counter.sv
// Row/column raster walker: column wraps at last_col into the next row; flags the final position.
module raster_counter #(
  parameter int unsigned  MAX_WIDTH  = 128,
  parameter int unsigned  MAX_HEIGHT = 128,
  localparam int unsigned ColW       = $clog2(MAX_WIDTH),
  localparam int unsigned RowW       = $clog2(MAX_HEIGHT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            advance,
  input  logic [ColW-1:0] last_col,
  input  logic [RowW-1:0] last_row,
  output logic [ColW-1:0] col,
  output logic [RowW-1:0] row,
  output logic            at_last
);

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            wrap;

  assign wrap    = (col_q == last_col);
  assign at_last = wrap && (row_q == last_row);
  assign col     = col_q;
  assign row     = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (wrap) begin
        col_d = '0;
        row_d = row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/padded_pixel_streamer.sv
// Streams an image surrounded by a one-pixel zero border into a line buffer, pulling interior
// pixels from an upstream valid/ready source.
module padded_pixel_streamer
  import padded_pixel_streamer_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned MAX_WIDTH  = DefMaxWidth,
  parameter int unsigned MAX_HEIGHT = DefMaxHeight
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       img_width,
  input  logic [31:0]       img_height,
  input  logic [DATA_W-1:0] s_pixel,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] pixel,
  output logic              data_valid,
  output logic [31:0]       curr_width,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int unsigned ColW = $clog2(MAX_WIDTH);
  localparam int unsigned RowW = $clog2(MAX_HEIGHT);

  state_e            state_q, state_d;
  logic [ColW-1:0]   last_col_q, col;
  logic [RowW-1:0]   last_row_q, row;
  logic [31:0]       curr_width_q;
  logic [DATA_W-1:0] pixel_q;
  logic              data_valid_q, cfg_err_q;
  logic              at_last, border, emit, accept, reject, cfg_bad;

  // Upper bounds are compared against MAX-2 so a huge W/H cannot wrap past the check.
  assign cfg_bad = (img_width == '0) || (img_height == '0) ||
                   (img_width > MAX_WIDTH - 32'd2) || (img_height > MAX_HEIGHT - 32'd2);

  assign border = (row == '0) || (row == last_row_q) || (col == '0) || (col == last_col_q);

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    emit    = 1'b0;
    accept  = 1'b0;
    reject  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          reject = cfg_bad;
          accept = !cfg_bad;
          if (!cfg_bad) state_d = StStream;
        end
      end
      StStream: begin
        s_ready = !border;
        emit    = border || s_valid;
        if (emit && at_last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  raster_counter #(
    .MAX_WIDTH  (MAX_WIDTH),
    .MAX_HEIGHT (MAX_HEIGHT)
  ) u_raster_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .advance  (emit),
    .last_col (last_col_q),
    .last_row (last_row_q),
    .col      (col),
    .row      (row),
    .at_last  (at_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_col_q   <= '0;
      last_row_q   <= '0;
      curr_width_q <= '0;
      pixel_q      <= '0;
      data_valid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_valid_q <= emit;
      cfg_err_q    <= reject;
      if (emit) pixel_q <= border ? '0 : s_pixel;
      if (accept) begin
        last_col_q   <= ColW'(img_width + 32'd1);
        last_row_q   <= RowW'(img_height + 32'd1);
        curr_width_q <= img_width + 32'd2;
      end
    end
  end

  assign pixel      = pixel_q;
  assign data_valid = data_valid_q;
  assign curr_width = curr_width_q;
  assign cfg_err    = cfg_err_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_padded_pixel_streamer.sv
// Scoreboard bench: a padded-frame model queues expected words, a negedge monitor checks them.
module tb_padded_pixel_streamer;

  localparam int unsigned DataW = 64;
  localparam int unsigned MaxW  = 128;
  localparam int unsigned MaxH  = 128;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [31:0]      img_width, img_height;
  logic [DataW-1:0] s_pixel;
  logic             s_valid;
  logic             s_ready;
  logic [DataW-1:0] pixel;
  logic             data_valid;
  logic [31:0]      curr_width;
  logic             busy, done, cfg_err;

  padded_pixel_streamer #(
    .DATA_W     (DataW),
    .MAX_WIDTH  (MaxW),
    .MAX_HEIGHT (MaxH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .img_width  (img_width),
    .img_height (img_height),
    .s_pixel    (s_pixel),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .pixel      (pixel),
    .data_valid (data_valid),
    .curr_width (curr_width),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int busy_cnt, stall_cnt, done_cnt, words_seen, cfg_cnt;
  bit abort = 1'b0;

  logic [DataW-1:0] exp_q[$];
  logic [DataW-1:0] pix_q[$];
  int               stall_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every valid word and tallies frame statistics.
  initial begin
    logic [DataW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy) busy_cnt++;
        if (s_ready && !s_valid) stall_cnt++;
        if (done) done_cnt++;
        if (cfg_err) cfg_cnt++;
        chk("s_ready_outside_stream", s_ready && (!busy || done), 0);
        if (data_valid) begin
          words_seen++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word: got %0h, expected no word", pixel);
          end else begin
            e = exp_q.pop_front();
            chk("pixel_word", pixel, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic fill_seq(input int w, input int h);
    pix_q.delete();
    stall_q.delete();
    for (int i = 1; i <= w * h; i++) begin
      pix_q.push_back(64'(i));
      stall_q.push_back(0);
    end
  endtask

  task automatic fill_random(input int w, input int h, input int max_stall);
    pix_q.delete();
    stall_q.delete();
    for (int i = 0; i < w * h; i++) begin
      pix_q.push_back({$urandom, $urandom});
      stall_q.push_back(int'($urandom_range(max_stall, 0)));
    end
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic run_frame(input int w, input int h);
    int k, n, budget;
    bit t;
    k = 0;
    n = (w + 2) * (h + 2);
    for (int r = 0; r < h + 2; r++)
      for (int c = 0; c < w + 2; c++)
        if (r == 0 || r == h + 1 || c == 0 || c == w + 1) exp_q.push_back('0);
        else exp_q.push_back(pix_q[k++]);
    busy_cnt = 0; stall_cnt = 0; done_cnt = 0; words_seen = 0;
    img_width = 32'(w); img_height = 32'(h); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    foreach (pix_q[i]) begin
      for (int s = 0; s < stall_q[i]; s++) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
        if (abort) return;
      end
      s_valid = 1'b1;
      s_pixel = pix_q[i];
      budget = 0;
      do begin
        @(negedge clk);
        t = s_ready;
        @(posedge clk); #1;
        if (abort) return;
        budget++;
      end while (!t && budget < 2000);
      if (!t) begin
        chk("feed_timeout", 1, 0);
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    s_pixel = {$urandom, $urandom};
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!done && !abort && budget < 20000);
    if (abort) begin
      @(posedge clk); #1;
      return;
    end
    chk("done_timeout", done, 1);
    @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("word_count", words_seen, n);
    chk("done_pulses", done_cnt, 1);
    chk("busy_cycles", busy_cnt, n + stall_cnt + 1);
    chk("busy_after_frame", busy, 0);
    chk("curr_width", curr_width, 32'(w + 2));
  endtask

  task automatic reject_case(input int w, input int h, input string name);
    cfg_cnt = 0;
    img_width = 32'(w); img_height = 32'(h); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, "_cfg_err"}, cfg_err, 1);
    chk({name, "_busy"}, busy, 0);
    @(posedge clk); #1;
    chk({name, "_cfg_err_clear"}, cfg_err, 0);
    chk({name, "_busy_after"}, busy, 0);
    chk({name, "_cfg_pulses"}, cfg_cnt, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; img_width = '0; img_height = '0;
    s_pixel = '0; s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_valid", data_valid, 0);
    chk("rst_pixel", pixel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_curr_width", curr_width, 0);
    chk("rst_s_ready", s_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill_seq(2, 2);
    run_frame(2, 2);

    pix_q = '{64'hAA};
    stall_q = '{0};
    run_frame(1, 1);

    fill_seq(3, 2);
    stall_q[1] = 3;
    run_frame(3, 2);
    chk("stall_cycles", stall_cnt, 3);

    reject_case(0, 2, "w_zero");
    reject_case(MaxW - 1, 2, "w_too_big");
    reject_case(2, 0, "h_zero");
    reject_case(2, MaxH - 1, "h_too_big");

    fill_random(MaxW - 2, 1, 0);
    run_frame(MaxW - 2, 1);
    fill_random(1, MaxH - 2, 0);
    run_frame(1, MaxH - 2);

    // Start pulsed mid-frame must be ignored.
    fill_random(3, 3, 1);
    fork
      run_frame(3, 3);
      begin
        repeat (8) @(posedge clk);
        #1;
        img_width = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("midframe_busy", busy, 1);
      end
    join

    // Asynchronous reset mid-frame, then a clean frame.
    fill_random(4, 4, 1);
    fork
      run_frame(4, 4);
      begin
        int k;
        for (k = 0; k < 2000; k++) begin
          @(posedge clk); #2;
          if (words_seen >= 7) break;
        end
        chk("reset_point_reached", words_seen >= 7, 1);
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        chk("midrst_data_valid", data_valid, 0);
        chk("midrst_pixel", pixel, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_curr_width", curr_width, 0);
        chk("midrst_s_ready", s_ready, 0);
        exp_q.delete();
      end
    join
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    abort = 1'b0;
    @(posedge clk); #1;
    fill_seq(2, 2);
    run_frame(2, 2);

    for (int f = 0; f < 6; f++) begin
      int w, h;
      w = int'($urandom_range(6, 1));
      h = int'($urandom_range(5, 1));
      fill_random(w, h, 2);
      run_frame(w, h);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/padded_pixel_streamer.md
PADDED_PIXEL_STREAMER -- requirements
Module: padded_pixel_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning pixel word width.
REQ-002 SHALL have parameter MAX_WIDTH, default 128, meaning maximum padded row length, matching the line buffer depth.
REQ-003 SHALL have parameter MAX_HEIGHT, default 128, meaning maximum padded row count.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: one-cycle frame start request.
REQ-007 SHALL have port img_width, input, 32 bits: unpadded width W, sampled on accepted start.
REQ-008 SHALL have port img_height, input, 32 bits: unpadded height H, sampled on accepted start.
REQ-009 SHALL have port s_pixel, input, DATA_W bits: upstream interior pixel.
REQ-010 SHALL have port s_valid, input, 1 bit: upstream pixel valid.
REQ-011 SHALL have port s_ready, output, 1 bit: streamer accepts s_pixel this cycle.
REQ-012 SHALL have port pixel, output, DATA_W bits: word to the line buffer, registered.
REQ-013 SHALL have port data_valid, output, 1 bit: pixel valid, registered.
REQ-014 SHALL have port curr_width, output, 32 bits: padded width W+2 for the line buffer.
REQ-015 SHALL have port busy, output, 1 bit: frame in progress.
REQ-016 SHALL have port done, output, 1 bit: one-cycle end-of-frame pulse.
REQ-017 SHALL have port cfg_err, output, 1 bit: one-cycle pulse on a rejected start.

Function
REQ-018 SHALL implement FSM IDLE -> STREAM -> DONE -> IDLE.
REQ-019 SHALL accept start only in IDLE; start SHALL be ignored in STREAM/DONE.
REQ-020 SHALL reject start when W==0, H==0, W+2>MAX_WIDTH or H+2>MAX_HEIGHT: cfg_err pulses next cycle, state stays IDLE.
REQ-021 On accepted start SHALL latch W, H; curr_width=W+2 from the next cycle, stable until next accepted start.
REQ-022 In STREAM SHALL walk positions (r,c), r 0..H+1, c 0..W+1, raster order, c fastest.
REQ-023 Border position (r==0, r==H+1, c==0 or c==W+1): SHALL emit zero word, data_valid=1 next cycle, advance; s_ready=0.
REQ-024 Interior position: s_ready=1 combinationally; on s_valid&&s_ready SHALL emit s_pixel with 1-cycle latency and advance; without s_valid, data_valid=0 next cycle and position held.
REQ-025 SHALL emit exactly (W+2)*(H+2) valid words per frame, no gaps except upstream stalls.
REQ-026 After the final word (H+1,W+1) SHALL enter DONE; done=1 for exactly one cycle, then IDLE.
REQ-027 busy SHALL be 1 in STREAM and DONE, 0 in IDLE.
REQ-028 Column wrap SHALL occur at c==W+1 (c->0, r++) with no idle cycle.
REQ-029 s_ready SHALL be 0 in IDLE and DONE; upstream data offered then is not consumed.
REQ-030 Counters SHALL be sized $clog2(MAX_WIDTH) / $clog2(MAX_HEIGHT); comparisons against W+1, H+1 computed at latch.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, counters 0, pixel=0, data_valid=0, done=0, cfg_err=0, busy=0, curr_width=0.
REQ-032 Reset mid-frame SHALL abandon the frame; the next accepted start SHALL produce a complete correct frame.

Structure
REQ-033 A shared package SHALL hold DATA_W, MAX_WIDTH, MAX_HEIGHT defaults and the FSM state enum typedef.
REQ-034 One sub-module, raster_counter (row/col counters with wrap and last-position flag), SHALL be instantiated; the rest is inline.

Verification
REQ-035 W=2,H=2, s_valid held 1, pixels 1..4 -> 16 words: 0,0,0,0, 0,1,2,0, 0,3,4,0, 0,0,0,0; curr_width=4; done once.
REQ-036 W=1,H=1, pixel AA -> 9 words, only word 4 is AA; others 0.
REQ-037 W=3,H=2, s_valid low 3 cycles before second interior pixel -> 3 data_valid=0 cycles, order unchanged, total 20 words.
REQ-038 start with W=0, then W=MAX_WIDTH-1 -> cfg_err pulse each, busy stays 0, no data_valid.
REQ-039 start pulsed again mid-frame with W=5 -> ignored; curr_width stays at first W+2.
REQ-040 rst_n low after 7 words of a W=4,H=4 frame -> outputs 0 immediately; new W=2,H=2 frame matches REQ-035.
